tft_power_sequencer: RTL



---
 rtl/tft_power_sequencer_if.sv | 22 ++
 rtl/tft_power_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/tft_power_sequencer_if.sv
// System-control side of the TFT power sequencer: the power request and brightness in,
// the panel enables, backlight PWM and status out.
interface tft_power_sequencer_if;
  logic       power_req;
  logic [7:0] duty;
  logic       TFT_EN;
  logic       pix_en;
  logic       TFT_DISP;
  logic       LED_EN;
  logic       ready;
  logic [2:0] pwr_state;

  modport master (
    output power_req, duty,
    input  TFT_EN, pix_en, TFT_DISP, LED_EN, ready, pwr_state
  );

  modport slave (
    input  power_req, duty,
    output TFT_EN, pix_en, TFT_DISP, LED_EN, ready, pwr_state
  );
endinterface

// File: rtl/tft_power_sequencer.sv
// Nexys3 TFT panel power-up/power-down sequencer with the t1..t4 hold times and
// a run-time-adjustable backlight PWM. All outputs come straight from flops.
module tft_power_sequencer #(
  parameter int T1_CYC     = 9000,
  parameter int T2_CYC     = 9000,
  parameter int T3_CYC     = 1440000,
  parameter int T4_CYC     = 900000,
  parameter int PWM_PERIOD = 900,
  parameter int CNT_W      = 32
) (
  input  logic                  TFT_CLK,
  input  logic                  reset,
  tft_power_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    EN_WAIT   = 3'd1,
    PIX_WAIT  = 3'd2,
    DISP_WAIT = 3'd3,
    ON        = 3'd4,
    BL_OFF    = 3'd5,
    PIX_OFF   = 3'd6,
    EN_LOW    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] T1_LAST  = CNT_W'(T1_CYC - 1);
  localparam logic [CNT_W-1:0] T2_LAST  = CNT_W'(T2_CYC - 1);
  localparam logic [CNT_W-1:0] T3_LAST  = CNT_W'(T3_CYC - 1);
  localparam logic [CNT_W-1:0] T4_LAST  = CNT_W'(T4_CYC - 1);
  localparam logic [15:0]      PWM_LAST = 16'(PWM_PERIOD - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_last;
  logic [15:0]      pwm_cnt, pwm_nx, thr, thr_nx, thr_calc;
  logic             expired;
  logic             en_q, pix_q, disp_q, led_q, ready_q;
  logic             en_nx, pix_nx, disp_nx, led_nx, ready_nx;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_last = '0;
    case (state)
      EN_WAIT:           cnt_last = T1_LAST;
      PIX_WAIT, PIX_OFF: cnt_last = T2_LAST;
      DISP_WAIT, BL_OFF: cnt_last = T3_LAST;
      EN_LOW:            cnt_last = T4_LAST;
      default:           cnt_last = '0;
    endcase
    expired = (cnt == cnt_last);

    // A dropped request during power-up wins over the timer; the power-down path always completes.
    case (state)
      OFF:       if (bus.power_req) state_nx = EN_WAIT;
      EN_WAIT:   if (!bus.power_req) state_nx = EN_LOW;  else if (expired) state_nx = PIX_WAIT;
      PIX_WAIT:  if (!bus.power_req) state_nx = EN_LOW;  else if (expired) state_nx = DISP_WAIT;
      DISP_WAIT: if (!bus.power_req) state_nx = PIX_OFF; else if (expired) state_nx = ON;
      ON:        if (!bus.power_req) state_nx = BL_OFF;
      BL_OFF:    if (expired) state_nx = PIX_OFF;
      PIX_OFF:   if (expired) state_nx = EN_LOW;
      EN_LOW:    if (expired) state_nx = OFF;
      default:   state_nx = OFF;
    endcase

    if (state_nx != state || state == OFF || state == ON) cnt_nx = '0;
    else                                                  cnt_nx = cnt + CNT_W'(1);

    pwm_nx = '0;
    if (state_nx == ON && state == ON) pwm_nx = (pwm_cnt == PWM_LAST) ? 16'd0 : pwm_cnt + 16'd1;

    // Brightness is sampled only at a period start so a period never mixes two duties.
    thr_calc = 16'(({16'd0, bus.duty} * 24'(PWM_PERIOD)) >> 8);
    thr_nx   = (pwm_nx == 16'd0) ? thr_calc : thr;

    en_nx   = 1'b0;
    pix_nx  = 1'b0;
    disp_nx = 1'b0;
    case (state_nx)
      EN_WAIT:                   en_nx = 1'b1;
      PIX_WAIT, PIX_OFF:         begin en_nx = 1'b1; pix_nx = 1'b1; end
      DISP_WAIT, ON, BL_OFF:     begin en_nx = 1'b1; pix_nx = 1'b1; disp_nx = 1'b1; end
      default:                   ;
    endcase
    ready_nx = (state_nx == ON);
    led_nx   = (state_nx == ON) && (pwm_nx < thr_nx);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the synchronous reset is just the first branch.
  always_ff @(posedge TFT_CLK) begin
    if (reset) begin
      state   <= OFF;
      cnt     <= '0;
      pwm_cnt <= '0;
      thr     <= '0;
      en_q    <= 1'b0;
      pix_q   <= 1'b0;
      disp_q  <= 1'b0;
      led_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pwm_cnt <= pwm_nx;
      thr     <= thr_nx;
      en_q    <= en_nx;
      pix_q   <= pix_nx;
      disp_q  <= disp_nx;
      led_q   <= led_nx;
      ready_q <= ready_nx;
    end
  end

  assign bus.TFT_EN    = en_q;
  assign bus.pix_en    = pix_q;
  assign bus.TFT_DISP  = disp_q;
  assign bus.LED_EN    = led_q;
  assign bus.ready     = ready_q;
  assign bus.pwr_state = state;

endmodule
